icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache with multi-word lines, burst refill and an invalidate-all (fence.i) sweep.
- Sits between the multicycle core's instruction fetch port and the memory arbiter.
- Successor to the two-way, one-word-line icache. Adds configurable ways and line length, invalid-way-first replacement, and a flush engine.

Parameters:
- ENTRIES_PER_WAY, 64, sets per way; power of two, >= 2.
- WAYS, 2, associativity; power of two, 1..8. WAYS=1 gives a direct-mapped cache.
- LINE_WORDS, 4, 32-bit words per line; power of two, 1..16.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_addr_i  in  32  fetch byte address. Bits [1:0] are ignored.
- cpu_valid_i  in  1  fetch request. Held high with a stable address until cpu_ready_o.
- cpu_dout_o  out  32  instruction word. Valid only while cpu_ready_o is high.
- cpu_ready_o  out  1  one-cycle completion pulse.
- flush_i  in  1  one-cycle pulse requesting invalidation of all lines.
- flush_busy_o  out  1  high from the cycle after flush_i is accepted until the sweep ends.
- ram_addr_o  out  32  word-aligned refill address.
- ram_rdata_i  in  32  refill data. Sampled when ram_ready_i is high.
- ram_valid_o  out  1  refill word request.
- ram_ready_i  in  1  refill word accepted and data present.

Behaviour:
- Address split:
  - word = addr[2+WO-1:2], where WO = log2(LINE_WORDS).
  - idx = next log2(ENTRIES_PER_WAY) bits above word.
  - tag = the remaining upper bits.
- Storage:
  - Tag RAM: one per way, synchronous read.
  - Data RAM: one per way, depth ENTRIES_PER_WAY*LINE_WORDS, synchronous read.
  - Valid bits: flops, WAYS*ENTRIES_PER_WAY.
  - Replacement pointer: per-set round-robin, log2(WAYS) bits; zero width when WAYS=1.
- Reset (async, resetn=0):
  - state=IDLE; all valid bits=0; all pointers=0.
  - cpu_ready_o=0, cpu_dout_o=0, ram_valid_o=0, ram_addr_o=0, flush_busy_o=0.
  - Reset mid-refill abandons the fill; the partial line stays invalid.
- States: IDLE, LOOKUP, RESP, REFILL, FLUSH.
- IDLE:
  - Pending flush (flush_i, or a latched flush) -> FLUSH. Flush has priority over a fetch.
  - Otherwise cpu_valid_i -> LOOKUP; tag/data RAMs are read at idx/word.
- LOOKUP (compare):
  - Hit in way w -> RESP, registering the way-w data.
  - More than one hit is illegal; the lowest way wins.
  - Miss -> REFILL.
    - Victim = lowest invalid way in the set; if all ways are valid, victim = pointer[idx].
    - Clear valid[victim][idx] on entry.
- RESP:
  - cpu_ready_o=1 with the data -> IDLE.
  - Hit latency: 3 cycles from cpu_valid_i rising to cpu_ready_o.
- REFILL:
  - Fetches the line in order, words 0..LINE_WORDS-1.
  - ram_addr_o = {tag, idx, cnt, 2'b00}.
  - ram_valid_o stays high across words.
  - Each cycle with ram_ready_i: write ram_rdata_i into victim data at {idx,cnt}, cnt++. If cnt equals the requested word, capture the data into an output register.
  - After the last word:
    - Write the tag and set valid.
    - pointer[idx] = victim+1 mod WAYS, advanced only when replacing a valid line.
    - cpu_ready_o=1 in the following cycle with the captured word -> IDLE.
  - ram_valid_o drops in the cycle after the last ram_ready_i.
  - Zero wait states: miss latency = 3 + LINE_WORDS cycles.
- FLUSH:
  - Clears valid bits for one set per cycle, sets 0..ENTRIES_PER_WAY-1, all ways at once.
  - Lasts ENTRIES_PER_WAY cycles; flush_busy_o is high for exactly that window.
  - Pointers reset to 0.
  - Requests arriving during FLUSH wait; cpu_ready_o is never asserted while flush_busy_o is high.
- flush_i arriving in LOOKUP/RESP/REFILL:
  - Latched; the current transaction completes normally.
  - FLUSH starts the cycle after IDLE is re-entered.
  - Repeated flush_i while latched or busy merges into one sweep.
- cpu_ready_o is high for exactly one cycle per request.
- A new request is not evaluated in the same cycle as cpu_ready_o.

Test Plan:
- Cold miss at 0x0000_0108 (defaults) -> ram_addr_o 0x100,0x104,0x108,0x10C with zero waits; cpu_ready_o at cycle 7 with the 0x108 word. A repeat fetch of 0x10C hits at cycle 3 with no ram_valid_o.
- Conflict: fill 0x0000_0000, 0x0000_0400, then 0x0000_0800 (same idx 0) -> the third fill evicts way 0 (pointer starts 0). Refetch 0x400 hits; refetch 0x000 misses.
- ram_ready_i low for 3 cycles before each word -> ram_valid_o held, address stable, data correct. Miss latency = 3 + 4*4 = 19 cycles.
- flush_i pulsed during a refill -> the refill completes and returns data; flush_busy_o high for exactly 64 cycles; every previously cached address then misses.
- flush_i together with cpu_valid_i in IDLE -> the flush runs first; cpu_ready_o arrives 64+3+4 cycles later.
- resetn low mid-refill after 2 words -> all outputs 0 immediately; a refetch of the same address misses and refetches all 4 words.

Source files
------------

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache with burst line refill and flush sweep
module icache_nway #(
    parameter int ENTRIES_PER_WAY = 64,
    parameter int WAYS            = 2,
    parameter int LINE_WORDS      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_valid_i,
    output logic [31:0] cpu_dout_o,
    output logic        cpu_ready_o,
    input  logic        flush_i,
    output logic        flush_busy_o,
    output logic [31:0] ram_addr_o,
    input  logic [31:0] ram_rdata_i,
    output logic        ram_valid_o,
    input  logic        ram_ready_i
);
    localparam int WO = $clog2(LINE_WORDS);
    localparam int IW = $clog2(ENTRIES_PER_WAY);
    localparam int TW = 30 - WO - IW;
    localparam int WW = (WO > 0) ? WO : 1;
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int DW = IW + WO;

    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, REFILL, FLUSH} state_t;

    function automatic logic [WW-1:0] word_of(input logic [31:0] a);
        return WW'((a >> 2) & 32'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [31:0] a);
        return IW'(a >> (2 + WO));
    endfunction

    function automatic logic [TW-1:0] tag_of(input logic [31:0] a);
        return TW'(a >> (2 + WO + IW));
    endfunction

    function automatic logic [DW-1:0] daddr(input logic [IW-1:0] i, input logic [WW-1:0] w);
        return (DW'(i) << WO) | DW'(w);
    endfunction

    state_t state_q, state_d;

    logic [TW-1:0]   tag_ram  [WAYS][ENTRIES_PER_WAY];
    logic [31:0]     data_ram [WAYS][ENTRIES_PER_WAY*LINE_WORDS];
    logic [TW-1:0]   tag_q    [WAYS];
    logic [31:0]     data_q   [WAYS];
    logic [WAYS-1:0] valid_q  [ENTRIES_PER_WAY];
    logic [PW-1:0]   ptr_q    [ENTRIES_PER_WAY];

    logic [31:0]   req_addr_q;
    logic [31:0]   resp_q;
    logic [PW-1:0] victim_q;
    logic          evict_q;
    logic [WW-1:0] cnt_q;
    logic [IW-1:0] fcnt_q;
    logic          flush_pend_q;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [WW-1:0] req_word;
    logic          flush_req, last_set, cnt_last, accept;
    logic          hit, all_valid;
    logic [PW-1:0] hit_way, victim;

    assign req_tag   = tag_of(req_addr_q);
    assign req_idx   = idx_of(req_addr_q);
    assign req_word  = word_of(req_addr_q);
    assign flush_req = flush_i | flush_pend_q;
    assign last_set  = (fcnt_q == IW'(ENTRIES_PER_WAY - 1));
    assign cnt_last  = (cnt_q == WW'(LINE_WORDS - 1));
    // A fetch waiting behind a sweep is taken on the sweep's final cycle.
    assign accept = cpu_valid_i &&
                    (((state_q == IDLE) && !flush_req && !cpu_ready_o) ||
                     ((state_q == FLUSH) && last_set));

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = ptr_q[req_idx];
        all_valid = &valid_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = PW'(w);
            end
            if (!valid_q[req_idx][w])
                victim = PW'(w);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ram_valid_o  = 1'b0;
        ram_addr_o   = 32'h0;
        flush_busy_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req)
                    state_d = FLUSH;
                else if (accept)
                    state_d = LOOKUP;
            end
            LOOKUP: state_d = hit ? RESP : REFILL;
            RESP:   state_d = IDLE;
            REFILL: begin
                ram_valid_o = 1'b1;
                ram_addr_o  = (req_addr_q & ~32'(LINE_WORDS * 4 - 1)) | (32'(cnt_q) << 2);
                if (ram_ready_i && cnt_last)
                    state_d = RESP;
            end
            FLUSH: begin
                flush_busy_o = 1'b1;
                if (last_set)
                    state_d = accept ? LOOKUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_addr_q   <= 32'h0;
            resp_q       <= 32'h0;
            victim_q     <= '0;
            evict_q      <= 1'b0;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            cpu_ready_o  <= 1'b0;
            cpu_dout_o   <= 32'h0;
            for (int e = 0; e < ENTRIES_PER_WAY; e++) begin
                valid_q[e] <= '0;
                ptr_q[e]   <= '0;
            end
        end else begin
            cpu_ready_o <= 1'b0;
            if (state_q == IDLE)
                flush_pend_q <= 1'b0;
            else if (state_q != FLUSH && flush_i)
                flush_pend_q <= 1'b1;
            if (accept)
                req_addr_q <= cpu_addr_i;
            case (state_q)
                LOOKUP: begin
                    if (hit) begin
                        resp_q <= data_q[hit_way];
                    end else begin
                        victim_q                 <= victim;
                        evict_q                  <= all_valid;
                        valid_q[req_idx][victim] <= 1'b0;
                        cnt_q                    <= '0;
                    end
                end
                REFILL: begin
                    if (ram_ready_i) begin
                        cnt_q <= cnt_q + WW'(1);
                        if (cnt_q == req_word)
                            resp_q <= ram_rdata_i;
                        if (cnt_last) begin
                            valid_q[req_idx][victim_q] <= 1'b1;
                            if (evict_q)
                                ptr_q[req_idx] <= (WAYS == 1) ? '0 : victim_q + PW'(1);
                        end
                    end
                end
                RESP: begin
                    cpu_ready_o <= 1'b1;
                    cpu_dout_o  <= resp_q;
                end
                FLUSH: begin
                    valid_q[fcnt_q] <= '0;
                    ptr_q[fcnt_q]   <= '0;
                    fcnt_q          <= fcnt_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Array storage carries no reset; only the valid bits decide what is cached.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w]  <= tag_ram[w][idx_of(cpu_addr_i)];
                data_q[w] <= data_ram[w][daddr(idx_of(cpu_addr_i), word_of(cpu_addr_i))];
            end
        end
        if (state_q == REFILL && ram_ready_i) begin
            data_ram[victim_q][daddr(req_idx, cnt_q)] <= ram_rdata_i;
            if (cnt_last)
                tag_ram[victim_q][req_idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - randomized self-checking bench for icache_nway against a set-associative model
module tb_icache_nway;
    localparam int E  = 64;
    localparam int NW = 2;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] cpu_addr_i;
    logic        cpu_valid_i;
    logic [31:0] cpu_dout_o;
    logic        cpu_ready_o;
    logic        flush_i;
    logic        flush_busy_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_rdata_i;
    logic        ram_valid_o;
    logic        ram_ready_i;

    icache_nway #(.ENTRIES_PER_WAY(E), .WAYS(NW), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_addr_i(cpu_addr_i), .cpu_valid_i(cpu_valid_i),
        .cpu_dout_o(cpu_dout_o), .cpu_ready_o(cpu_ready_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .ram_addr_o(ram_addr_o), .ram_rdata_i(ram_rdata_i),
        .ram_valid_o(ram_valid_o), .ram_ready_i(ram_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Reference model: tags, valid flags and round-robin pointers per set.
    int m_tag [NW][E];
    bit m_val [NW][E];
    int m_ptr [E];

    function automatic int m_set(input logic [31:0] a);
        return int'((a / (4 * LW)) % E);
    endfunction

    function automatic int m_tg(input logic [31:0] a);
        return int'(a / (4 * LW * E));
    endfunction

    task automatic model_clear();
        for (int s = 0; s < E; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) m_val[w][s] = 1'b0;
        end
    endtask

    function automatic int model_lookup(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (m_val[w][m_set(a)] && m_tag[w][m_set(a)] == m_tg(a)) return w;
        return -1;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int s, v;
        s = m_set(a);
        v = -1;
        for (int w = 0; w < NW; w++)
            if (!m_val[w][s] && v < 0) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (v + 1) % NW;
        end
        m_tag[v][s] = m_tg(a);
        m_val[v][s] = 1'b1;
    endtask

    // Memory responder: wait_mode >= 0 fixes the stall before each word, -1 randomizes it.
    logic [31:0] q_addr[$];
    int          q_wait[$];
    int          wait_mode = 0;
    int          cur_wait = 0;
    int          wcnt = 0;
    int          addr_moved = 0;
    logic [31:0] held_addr = 32'h0;

    task automatic set_wait(input int m);
        wait_mode = m;
        cur_wait  = (m < 0) ? int'($urandom_range(0, 3)) : m;
    endtask

    initial begin
        ram_ready_i = 1'b0;
        ram_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (ram_valid_o && resetn) begin
                if (wcnt == cur_wait) begin
                    ram_ready_i = 1'b1;
                    ram_rdata_i = mem(ram_addr_o);
                    q_addr.push_back(ram_addr_o);
                    q_wait.push_back(cur_wait);
                    wcnt = 0;
                    cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                end else begin
                    ram_ready_i = 1'b0;
                    ram_rdata_i = 32'hDEAD_BEEF;
                    if (wcnt > 0 && ram_addr_o != held_addr) addr_moved++;
                    held_addr = ram_addr_o;
                    wcnt++;
                end
            end else begin
                ram_ready_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    bit prev_ready = 1'b0;
    initial forever begin
        @(negedge clk);
        if (resetn && cpu_ready_o)
            chk("ready_pulse_busy_or_repeat", {30'h0, flush_busy_o, prev_ready}, 32'h0);
        prev_ready = cpu_ready_o;
    end

    int          last_lat;
    logic [31:0] last_data;

    task automatic fetch(input logic [31:0] a, input bit with_flush, output int lat, output logic [31:0] data);
        q_addr.delete();
        q_wait.delete();
        cpu_addr_i  = a;
        cpu_valid_i = 1'b1;
        flush_i     = with_flush;
        lat  = 0;
        data = 'x;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            if (with_flush) flush_i = 1'b0;
            lat++;
            if (cpu_ready_o) begin
                data = cpu_dout_o;
                break;
            end
        end
        cpu_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit with_flush);
        int          way, exp_lat;
        logic [31:0] line;
        if (with_flush) model_clear();
        way  = model_lookup(a);
        line = a & ~32'(LW * 4 - 1);
        fetch(a, with_flush, last_lat, last_data);
        chk("data", last_data, mem(a & ~32'h3));
        exp_lat = 3;
        if (way >= 0) begin
            chk("hit_ram_words", q_addr.size(), 0);
        end else begin
            chk("refill_words", q_addr.size(), LW);
            for (int k = 0; k < LW && k < q_addr.size(); k++) begin
                chk("refill_addr", q_addr[k], line + 32'(4 * k));
                exp_lat += q_wait[k] + 1;
            end
            model_fill(a);
        end
        if (with_flush) exp_lat += E;
        chk("latency", last_lat, exp_lat);
    endtask

    task automatic measure_busy(output int dly, output int len);
        dly = 0;
        while (!flush_busy_o && dly < 10) begin @(posedge clk); #1; dly++; end
        len = 0;
        while (flush_busy_o && len < 200) begin @(posedge clk); #1; len++; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_a [4];
        int dly, len, n;
        resetn      = 1'b0;
        cpu_addr_i  = 32'h0;
        cpu_valid_i = 1'b0;
        flush_i     = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cpu_ready_o, 0);
        chk("rst_dout", cpu_dout_o, 0);
        chk("rst_ram_valid", ram_valid_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_busy", flush_busy_o, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_fetch(32'h0000_0108, 1'b0);
        chk("cold_lat", last_lat, 7);
        chk("cold_data", last_data, 32'hC0DE_0108);
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        for (int k = 0; k < 4; k++) chk("cold_addr", q_addr[k], exp_a[k]);
        do_fetch(32'h0000_010C, 1'b0);
        chk("hit_lat", last_lat, 3);
        chk("hit_data", last_data, 32'hC0DE_010C);

        do_fetch(32'h0000_0000, 1'b0);
        do_fetch(32'h0000_0400, 1'b0);
        do_fetch(32'h0000_0800, 1'b0);
        do_fetch(32'h0000_0400, 1'b0);
        chk("conflict_keep_lat", last_lat, 3);
        do_fetch(32'h0000_0000, 1'b0);
        chk("conflict_evict_lat", last_lat, 7);

        set_wait(3);
        addr_moved = 0;
        do_fetch(32'h0000_2004, 1'b0);
        chk("wait_lat", last_lat, 19);
        chk("wait_addr_stable", addr_moved, 0);
        set_wait(0);

        fork
            do_fetch(32'h0000_3000, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #2 flush_i = 1'b1;
                @(posedge clk);
                #2 flush_i = 1'b0;
            end
        join
        measure_busy(dly, len);
        chk("flush_after_refill_delay", dly, 0);
        chk("flush_len", len, 64);
        model_clear();
        do_fetch(32'h0000_0108, 1'b0);
        chk("post_flush_miss_lat", last_lat, 7);
        do_fetch(32'h0000_3000, 1'b0);

        do_fetch(32'h0000_4000, 1'b1);
        chk("flush_first_lat", last_lat, 71);

        q_addr.delete();
        cpu_addr_i  = 32'h0000_5008;
        cpu_valid_i = 1'b1;
        n = 0;
        while (q_addr.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("reset_prep_in_time", n < 50, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_ready", cpu_ready_o, 0);
        chk("midrst_dout", cpu_dout_o, 0);
        chk("midrst_ram_valid", ram_valid_o, 0);
        chk("midrst_ram_addr", ram_addr_o, 0);
        chk("midrst_busy", flush_busy_o, 0);
        cpu_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        do_fetch(32'h0000_5008, 1'b0);
        chk("midrst_refetch_lat", last_lat, 7);
        do_fetch(32'h0000_0108, 1'b0);
        chk("midrst_old_line_lat", last_lat, 7);

        set_wait(-1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                flush_i = 1'b1;
                @(posedge clk);
                #1 flush_i = 1'b0;
                measure_busy(dly, len);
                chk("rand_flush_len", len, 64);
                model_clear();
            end else begin
                do_fetch((32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 2)) << 4) |
                         (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
